// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Groups the request/response handshake and the word-wide memory port of the
// load/store unit into one bundle.
//   slave  : the load/store unit's view. Requests and memory read data come in;
//            response, status and memory command signals go out.
//   master : the requester/memory side's view (the exact mirror of slave).
// mem_addr is a word index, and mem_rdata must be combinational for the
// current mem_addr.
interface load_store_unit_if;
    // request channel
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    // response channel
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err_misaligned;
    logic        err_fault;
    logic        busy;
    // memory port
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, is_store, funct3, addr, wdata, mem_rdata,
        output req_ready, resp_valid, rdata, err_misaligned, err_fault, busy,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, is_store, funct3, addr, wdata, mem_rdata,
        input  req_ready, resp_valid, rdata, err_misaligned, err_fault, busy,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// RV32I-style byte/halfword/word load/store engine in front of a 64-word
// memory with a combinational read port.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : load_store_unit_if.slave. It carries the req_valid/req_ready
//                handshake with is_store/funct3/addr/wdata, the one-cycle
//                resp_valid pulse with rdata/err_misaligned/err_fault, busy,
//                and the mem_read/mem_write/mem_addr/mem_wdata/mem_rdata port.
// Flow:
//   load           IDLE -> LOAD -> RESP
//   SW             IDLE -> STORE_WR -> RESP
//   SB/SH          IDLE -> STORE_RD -> STORE_WR -> RESP
//                  (read-modify-write of the enclosing word)
//   faulting or
//   misaligned     IDLE -> RESP (no memory traffic)
module load_store_unit (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        STORE_RD = 3'd2,
        STORE_WR = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] old_word_q, old_word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_mis_q, err_mis_d;
    logic        err_fault_q, err_fault_d;

    // Only addr_q[7:0] reaches the memory. The upper bits are latched for
    // completeness; they were already checked at acceptance time.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[31:8];

    // ------------------------------------------------------------------
    // Request decode on the live request inputs (used only in IDLE).
    // A fault takes priority, so misalignment is reported only when the
    // access is otherwise legal.
    // ------------------------------------------------------------------
    logic req_fault, req_mis;
    always_comb begin
        req_fault = 1'b0;
        if (bus.addr[31:8] != 24'd0) begin
            req_fault = 1'b1;
        end
        if (bus.is_store) begin
            if (bus.funct3 >= 3'd3) begin
                req_fault = 1'b1;
            end
        end else if (bus.funct3 == 3'd3 || bus.funct3 == 3'd6 || bus.funct3 == 3'd7) begin
            req_fault = 1'b1;
        end

        req_mis = 1'b0;
        if (!req_fault) begin
            case (bus.funct3)
                3'd1, 3'd5: req_mis = bus.addr[0];
                3'd2:       req_mis = |bus.addr[1:0];
                default:    req_mis = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load lane extraction from the word that is currently being read.
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    always_comb begin
        ld_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Store merge: each byte lane takes either the new data or the old
    // word. For SW every lane is enabled, so the old word drops out.
    // ------------------------------------------------------------------
    logic [3:0]  lane_en;
    logic [31:0] merged_word;
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   lane_en = 4'b0001 << addr_q[1:0];
            2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] src_byte;
            // SB replicates the low byte into every lane, SH replicates the
            // low halfword into both halves, and SW passes bytes straight through.
            assign src_byte = (funct3_q[1:0] == 2'b00) ? wdata_q[7:0] :
                              (funct3_q[1:0] == 2'b01) ? wdata_q[8*(gi%2) +: 8] :
                                                         wdata_q[8*gi +: 8];
            assign merged_word[8*gi +: 8] = lane_en[gi] ? src_byte : old_word_q[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            old_word_q  <= 32'd0;
            rdata_q     <= 32'd0;
            err_mis_q   <= 1'b0;
            err_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            old_word_q  <= old_word_d;
            rdata_q     <= rdata_d;
            err_mis_q   <= err_mis_d;
            err_fault_q <= err_fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        old_word_d  = old_word_q;
        rdata_d     = rdata_q;
        err_mis_d   = err_mis_q;
        err_fault_d = err_fault_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    is_store_d  = bus.is_store;
                    funct3_d    = bus.funct3;
                    addr_d      = bus.addr;
                    wdata_d     = bus.wdata;
                    rdata_d     = 32'd0;
                    err_fault_d = req_fault;
                    err_mis_d   = req_mis;
                    if (req_fault || req_mis) begin
                        state_d = RESP;
                    end else if (!bus.is_store) begin
                        state_d = LOAD;
                    end else if (bus.funct3 == 3'd2) begin
                        state_d = STORE_WR;
                    end else begin
                        state_d = STORE_RD;
                    end
                end
            end
            LOAD: begin
                rdata_d = ld_data;
                state_d = RESP;
            end
            STORE_RD: begin
                old_word_d = bus.mem_rdata;
                state_d    = STORE_WR;
            end
            STORE_WR: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Everything except mem_addr is decoded from the current state.
    // ------------------------------------------------------------------
    always_comb begin
        bus.req_ready      = (state_q == IDLE);
        bus.busy           = (state_q != IDLE);
        bus.resp_valid     = 1'b0;
        bus.rdata          = 32'd0;
        bus.err_misaligned = 1'b0;
        bus.err_fault      = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_wdata      = 32'd0;
        bus.mem_addr       = {26'd0, addr_q[7:2]};

        case (state_q)
            LOAD:     bus.mem_read = 1'b1;
            STORE_RD: bus.mem_read = 1'b1;
            STORE_WR: begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = merged_word;
            end
            RESP: begin
                bus.resp_valid     = 1'b1;
                bus.rdata          = is_store_q ? 32'd0 : rdata_q;
                bus.err_misaligned = err_mis_q;
                bus.err_fault      = err_fault_q;
            end
            default: ;
        endcase
    end
endmodule
